// File: rtl/lfsr_pkg.sv
// Shared constants for the 19-bit XOR LFSR (taps 18,5,1,0) checker and its generator.
package lfsr_pkg;

  localparam int LFSR_W = 19;
  localparam int TAP_3  = 18;
  localparam int TAP_2  = 5;
  localparam int TAP_1  = 1;
  localparam int TAP_0  = 0;

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lfsr_state_e;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_3] ^ s[TAP_2] ^ s[TAP_1] ^ s[TAP_0];
  endfunction

endpackage

// File: rtl/lfsr_sat_cnt.sv
// 16-bit saturating counter; a clear coinciding with an increment leaves a count of 1.
module lfsr_sat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {15'd0, inc_i};
    end else if (inc_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_chk.sv
// PRBS checker for the 19-bit LFSR stream: acquire, verify, then lock onto a free-running reference.
// Error counter is built only when LFSR_CHK_ERR_CNT_EN is defined.
module lfsr_chk
  import lfsr_pkg::*;
#(
  parameter int LOCK_THR = 32,
  parameter int LOSS_THR = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_i,
  input  logic        bit_en,
  input  logic        err_clr,
  output logic        lock_o,
  output logic        err_o,
  output logic [15:0] err_cnt_o,
  output logic [1:0]  state_o
);

  localparam int MATCH_W = $clog2(LOCK_THR + 1);
  localparam int MISS_W  = $clog2(LOSS_THR + 1);

  lfsr_state_e         state_q, state_d;
  logic [LFSR_W-1:0]   hist_q, hist_d;
  logic [4:0]          fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                lock_q, lock_d;
  logic                err_q, err_d;
  logic                pred;
  logic                miss_evt;

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_d    = 1'b0;
    miss_evt = 1'b0;
    pred     = lfsr_fb(hist_q);

    case (state_q)
      ST_ACQ: begin
        if (bit_en) begin
          hist_d = {hist_q[LFSR_W-2:0], bit_i};
          if (int'(fill_q) == LFSR_W - 1) begin
            fill_d  = 5'(LFSR_W);
            match_d = '0;
            state_d = ST_VERIFY;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
      end

      ST_VERIFY: begin
        if (bit_en) begin
          hist_d = {hist_q[LFSR_W-2:0], bit_i};
          if (bit_i != pred) begin
            match_d = '0;
          end else if (hist_q != '0) begin
            // An all-zero history predicts zeros forever, so it never earns a match.
            if (int'(match_q) == LOCK_THR - 1) begin
              match_d = '0;
              miss_d  = '0;
              state_d = ST_LOCKED;
            end else begin
              match_d = match_q + 1'b1;
            end
          end
        end
      end

      ST_LOCKED: begin
        if (bit_en) begin
          // Reference runs on its own prediction so a bad bit cannot corrupt later predictions.
          hist_d = {hist_q[LFSR_W-2:0], pred};
          if (bit_i != pred) begin
            err_d    = 1'b1;
            miss_evt = 1'b1;
            if (int'(miss_q) == LOSS_THR - 1) begin
              miss_d  = '0;
              fill_d  = '0;
              state_d = ST_ACQ;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_ACQ;
        fill_d  = '0;
        match_d = '0;
        miss_d  = '0;
      end
    endcase

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACQ;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign lock_o  = lock_q;
  assign err_o   = err_q;
  assign state_o = state_q;

`ifdef LFSR_CHK_ERR_CNT_EN
  lfsr_sat_cnt u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (err_clr),
    .inc_i (miss_evt),
    .cnt_o (err_cnt_o)
  );
`else
  logic unused_err_cnt_in;
  assign unused_err_cnt_in = err_clr ^ miss_evt;
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lfsr_chk.sv
// Directed bench for lfsr_chk: acquisition, lock, single errors, loss of lock, saturation, resets.
module tb_lfsr_chk;

`ifdef LFSR_CHK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int LOCK_N   = 32;
  localparam int LOSS_N   = 8;
  localparam int SAT_INJ  = 65540;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        bit_i = 1'b0;
  logic        bit_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        lock_o;
  logic        err_o;
  logic [15:0] err_cnt_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad = 0;
  int err_hits = 0;
  int mdl_cnt = 0;
  logic [18:0] gen_q = 19'd1;

  lfsr_chk #(.LOCK_THR(LOCK_N), .LOSS_THR(LOSS_N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_i     (bit_i),
    .bit_en    (bit_en),
    .err_clr   (err_clr),
    .lock_o    (lock_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference generator: emits the MSB, then shifts in the tap XOR.
  task automatic gen_bit(output logic b);
    b = gen_q[18];
    gen_q = {gen_q[17:0], gen_q[18] ^ gen_q[5] ^ gen_q[1] ^ gen_q[0]};
  endtask

  task automatic count_err();
    if (mdl_cnt < 65535) mdl_cnt++;
  endtask

  function automatic logic [31:0] exp_cnt();
    return CNT_EN ? 32'(mdl_cnt) : 32'd0;
  endfunction

  task automatic step(input logic b, input logic en, input logic clr);
    bit_i = b;
    bit_en = en;
    err_clr = clr;
    @(posedge clk);
    #1;
    if (err_o) err_hits++;
    err_clr = 1'b0;
  endtask

  task automatic rst_pulse(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_lock"}, 32'(lock_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_cnt"}, 32'(err_cnt_o), 32'd0);
    mdl_cnt = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic lock_seq(input int period, input string tag);
    logic gb;
    gen_q = 19'd1;
    err_hits = 0;
    for (int i = 1; i <= 19 + LOCK_N; i++) begin
      for (int j = 1; j < period; j++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      gen_bit(gb);
      step(gb, 1'b1, 1'b0);
      if (i == 18) chk({tag, "_acq_at18"}, 32'(state_o), 32'd0);
      if (i == 19) chk({tag, "_verify_at19"}, 32'(state_o), 32'd1);
      if (i == 18 + LOCK_N) chk({tag, "_nolock_at50"}, 32'(lock_o), 32'd0);
      if (i == 19 + LOCK_N) begin
        chk({tag, "_lock_at51"}, 32'(lock_o), 32'd1);
        chk({tag, "_locked_state"}, 32'(state_o), 32'd2);
      end
    end
    chk({tag, "_no_err"}, 32'(err_hits), 32'd0);
  endtask

  initial begin
    logic gb;
    int miss;
    bit lost;
    int injected;

    // Reset state, checked before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_lock", 32'(lock_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_cnt", 32'(err_cnt_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    lock_seq(1, "acq");

    // One inverted bit while locked, then an idle cycle and a good bit.
    for (int i = 0; i < 5; i++) begin
      gen_bit(gb);
      step(gb, 1'b1, 1'b0);
    end
    gen_bit(gb);
    step(~gb, 1'b1, 1'b0);
    count_err();
    chk("single_err_pulse", 32'(err_o), 32'd1);
    chk("single_err_cnt", 32'(err_cnt_o), exp_cnt());
    chk("single_err_lock", 32'(lock_o), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("idle_err_low", 32'(err_o), 32'd0);
    chk("idle_state_hold", 32'(state_o), 32'd2);
    gen_bit(gb);
    step(gb, 1'b1, 1'b0);
    chk("after_err_low", 32'(err_o), 32'd0);
    chk("after_err_lock", 32'(lock_o), 32'd1);
    chk("after_err_cnt", 32'(err_cnt_o), exp_cnt());

    // Constant-zero line: mismatches occur where the reference predicts 1.
    miss = 0;
    lost = 1'b0;
    for (int i = 0; i < 4000 && !lost; i++) begin
      gen_bit(gb);
      step(1'b0, 1'b1, 1'b0);
      if (gb) begin
        miss++;
        count_err();
      end else begin
        miss = 0;
      end
      chk("zero_err_o", 32'(err_o), 32'(gb));
      if (miss == LOSS_N) begin
        lost = 1'b1;
        chk("loss_lock", 32'(lock_o), 32'd0);
        chk("loss_state", 32'(state_o), 32'd0);
        chk("loss_cnt", 32'(err_cnt_o), exp_cnt());
      end else begin
        chk("zero_still_locked", 32'(lock_o), 32'd1);
      end
    end
    chk("loss_reached", 32'(lost), 32'd1);
    err_hits = 0;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
    chk("zero_no_relock", 32'(lock_o), 32'd0);
    chk("zero_stuck_verify", 32'(state_o), 32'd1);
    chk("zero_no_err", 32'(err_hits), 32'd0);

    // Reset in VERIFY, then acquire with bit_en active one cycle in three.
    rst_pulse("rst_verify");
    lock_seq(3, "gated");

    // Reset in LOCKED with an error pulse and count pending, then reacquire.
    gen_bit(gb);
    step(~gb, 1'b1, 1'b0);
    count_err();
    chk("pre_rst_err", 32'(err_o), 32'd1);
    rst_pulse("rst_locked");
    lock_seq(1, "reacq");

    // Saturation: bursts of 7 errors separated by a good bit keep the lock.
    injected = 0;
    for (int k = 0; k < 10000 && injected < SAT_INJ; k++) begin
      for (int j = 0; j < 7; j++) begin
        if (injected < SAT_INJ) begin
          gen_bit(gb);
          step(~gb, 1'b1, 1'b0);
          injected++;
          count_err();
          if (injected == 65534 || injected == 65535 || injected == SAT_INJ)
            chk("sat_cnt", 32'(err_cnt_o), exp_cnt());
        end
      end
      gen_bit(gb);
      step(gb, 1'b1, 1'b0);
    end
    chk("sat_injected", 32'(injected), 32'(SAT_INJ));
    chk("sat_lock", 32'(lock_o), 32'd1);
    chk("sat_final", 32'(err_cnt_o), exp_cnt());

    // Clear together with an error leaves one; clear alone leaves zero.
    gen_bit(gb);
    step(~gb, 1'b1, 1'b1);
    mdl_cnt = 1;
    chk("clr_err_pulse", 32'(err_o), 32'd1);
    chk("clr_with_err", 32'(err_cnt_o), exp_cnt());
    gen_bit(gb);
    step(gb, 1'b1, 1'b1);
    mdl_cnt = 0;
    chk("clr_alone", 32'(err_cnt_o), exp_cnt());
    chk("clr_lock", 32'(lock_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
